// File: rtl/if_id_stall_register_pkg.sv
// Shared definitions for the IF/ID stall register: FSM state encoding and the NOP encoding.
package if_id_stall_register_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALLED = 2'd1,
    FLUSHED = 2'd2
  } id_state_e;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR_ENC = 32'h0000_0000;

endpackage : if_id_stall_register_pkg

// File: rtl/if_id_stall_register_stall_watchdog.sv
// Stall watchdog: saturating count of consecutive stall cycles plus a sticky timeout flag.
module stall_watchdog #(
  parameter int MAX_STALL_CYCLES = 8,
  parameter int CNT_WIDTH        = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_stall,
  output logic o_timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = CNT_WIDTH'(MAX_STALL_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX_M1  = CNT_WIDTH'(MAX_STALL_CYCLES - 1);

  logic [CNT_WIDTH-1:0] run_cnt_q;
  logic                 timeout_q;

  // A frozen pipeline neither extends nor breaks the current stall run.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else if (i_enable) begin
      if (i_stall) begin
        if (run_cnt_q != CNT_MAX) run_cnt_q <= run_cnt_q + 1'b1;
        if (run_cnt_q >= CNT_MAX_M1) timeout_q <= 1'b1;
      end else begin
        run_cnt_q <= '0;
      end
    end
  end

  assign o_timeout = timeout_q;

endmodule : stall_watchdog

// File: rtl/if_id_stall_register.sv
// IF/ID pipeline register with stall hold, jump squash and stall watchdog.
// Optional statistics ports are enabled by defining IF_ID_STALL_STATS_EN.
module if_id_stall_register
  import if_id_stall_register_pkg::*;
#(
  parameter int                    DATA_WIDTH       = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR        = DATA_WIDTH'(NOP_INSTR_ENC),
  parameter int                    MAX_STALL_CYCLES = 8,
  parameter int                    CNT_WIDTH        = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_jump_taken,
  input  logic [DATA_WIDTH-1:0] i_if_instruction,
  input  logic [DATA_WIDTH-1:0] i_if_pc_plus4,
  output logic                  o_pc_write,
  output logic [DATA_WIDTH-1:0] o_id_instruction,
  output logic [DATA_WIDTH-1:0] o_id_pc_plus4,
  output logic                  o_id_valid,
  output logic                  o_id_ex_bubble,
`ifdef IF_ID_STALL_STATS_EN
  output logic [31:0]           o_stall_cycles,
  output logic [31:0]           o_flush_count,
`endif
  output logic                  o_stall_timeout
);

  id_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] id_instr_q, id_instr_d;
  logic [DATA_WIDTH-1:0] id_pc_q, id_pc_d;
  logic                  id_valid_q, id_valid_d;

  // A stalled branch in ID has not resolved yet, so stall outranks jump.
  // NOTE: every always_comb output is defaulted first so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    if (i_enable) begin
      if (i_stall) begin
        state_d = STALLED;
      end else if (i_jump_taken) begin
        state_d    = FLUSHED;
        id_instr_d = NOP_INSTR;
        id_pc_d    = i_if_pc_plus4;
        id_valid_d = 1'b0;
      end else begin
        state_d    = RUN;
        id_instr_d = i_if_instruction;
        id_pc_d    = i_if_pc_plus4;
        id_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= RUN;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign o_pc_write       = ~i_rst & i_enable & ~i_stall;
  assign o_id_ex_bubble   = ~i_rst & i_enable & i_stall;
  assign o_id_instruction = id_instr_q;
  assign o_id_pc_plus4    = id_pc_q;
  assign o_id_valid       = id_valid_q;

  stall_watchdog #(
    .MAX_STALL_CYCLES (MAX_STALL_CYCLES),
    .CNT_WIDTH        (CNT_WIDTH)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_enable  (i_enable),
    .i_stall   (i_stall),
    .o_timeout (o_stall_timeout)
  );

`ifdef IF_ID_STALL_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;
  logic        flush_event;

  assign flush_event = i_enable & ~i_stall & i_jump_taken;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (i_enable && i_stall && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 1'b1;
      if (flush_event && flush_count_q != '1)          flush_count_q  <= flush_count_q + 1'b1;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_count  = flush_count_q;
`endif

endmodule : if_id_stall_register

// File: tb/tb_if_id_stall_register.sv
// Directed self-checking bench for if_id_stall_register (default and IF_ID_STALL_STATS_EN builds).
module tb_if_id_stall_register;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        stall;
  logic        jump_taken;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_plus4;
  logic        pc_write;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        id_ex_bubble;
  logic        stall_timeout;
`ifdef IF_ID_STALL_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int total = 0;
  int bad   = 0;

  if_id_stall_register dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (enable),
    .i_stall          (stall),
    .i_jump_taken     (jump_taken),
    .i_if_instruction (if_instruction),
    .i_if_pc_plus4    (if_pc_plus4),
    .o_pc_write       (pc_write),
    .o_id_instruction (id_instruction),
    .o_id_pc_plus4    (id_pc_plus4),
    .o_id_valid       (id_valid),
    .o_id_ex_bubble   (id_ex_bubble),
`ifdef IF_ID_STALL_STATS_EN
    .o_stall_cycles   (stall_cycles),
    .o_flush_count    (flush_count),
`endif
    .o_stall_timeout  (stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc, input logic valid);
    check({tag, ".instr"}, id_instruction, instr);
    check({tag, ".pc4"},   id_pc_plus4,    pc);
    check({tag, ".valid"}, 32'(id_valid),  32'(valid));
  endtask

  task automatic check_ctl(input string tag, input logic pcw, input logic bub);
    check({tag, ".pc_write"}, 32'(pc_write),     32'(pcw));
    check({tag, ".bubble"},   32'(id_ex_bubble), 32'(bub));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b1;
    stall          = 1'b0;
    jump_taken     = 1'b0;
    if_instruction = 32'h0;
    if_pc_plus4    = 32'h0;
    #2;
    check_id("reset", 32'h0, 32'h0, 1'b0);
    check("reset.timeout", 32'(stall_timeout), 32'h0);
    check_ctl("reset", 1'b0, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check_ctl("run_idle", 1'b1, 1'b0);

    // Advance a lw into ID.
    if_instruction = 32'h8C22_0004; if_pc_plus4 = 32'h4;
    step();
    check_id("adv_lw", 32'h8C22_0004, 32'h4, 1'b1);

    // One-cycle load-use stall: hold ID, PC frozen, bubble raised.
    stall = 1'b1; if_instruction = 32'h0043_2020; if_pc_plus4 = 32'h8;
    #1;
    check_ctl("loaduse", 1'b0, 1'b1);
    step();
    check_id("loaduse_hold", 32'h8C22_0004, 32'h4, 1'b1);
    stall = 1'b0;
    step();
    check_id("after_stall", 32'h0043_2020, 32'h8, 1'b1);

    // Jump squashes the fetched word.
    jump_taken = 1'b1; if_instruction = 32'h2001_0005; if_pc_plus4 = 32'h10;
    step();
    check_id("jump", 32'h0, 32'h10, 1'b0);
    // Jump again while FLUSHED: flush repeats.
    if_instruction = 32'h1234_5678; if_pc_plus4 = 32'h14;
    step();
    check_id("jump_again", 32'h0, 32'h14, 1'b0);
`ifdef IF_ID_STALL_STATS_EN
    check("stats.flush2", flush_count, 32'd2);
`endif

    jump_taken = 1'b0; if_instruction = 32'h8C22_0004; if_pc_plus4 = 32'h18;
    step();
    check_id("adv2", 32'h8C22_0004, 32'h18, 1'b1);

    // Stall and jump together: stall wins, no flush.
    stall = 1'b1; jump_taken = 1'b1; if_instruction = 32'hAAAA_AAAA; if_pc_plus4 = 32'h1C;
    #1;
    check_ctl("stall_jump", 1'b0, 1'b1);
    step();
    check_id("stall_jump_hold", 32'h8C22_0004, 32'h18, 1'b1);
`ifdef IF_ID_STALL_STATS_EN
    check("stats.flush_nostall", flush_count, 32'd2);
`endif
    stall = 1'b0; jump_taken = 1'b0; if_instruction = 32'h0043_2020; if_pc_plus4 = 32'h1C;
    step();
    check_id("adv3", 32'h0043_2020, 32'h1C, 1'b1);

    // Three stall cycles, then freeze with stall still asserted.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("run3.timeout", 32'(stall_timeout), 32'h0);
    enable = 1'b0; if_instruction = 32'h5555_5555; if_pc_plus4 = 32'h40;
    #1;
    check_ctl("frozen", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check_id("frozen_hold", 32'h0043_2020, 32'h1C, 1'b1);
    check("frozen.timeout", 32'(stall_timeout), 32'h0);
`ifdef IF_ID_STALL_STATS_EN
    check("stats.frozen_stalls", stall_cycles, 32'd5);
`endif
    // Resume: counter continues from 3, so edges 4..7 stay quiet and the 8th trips.
    enable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("run7.timeout", 32'(stall_timeout), 32'h0);
    step();
    check("run8.timeout", 32'(stall_timeout), 32'h1);
    stall = 1'b0; if_instruction = 32'h8C22_0004; if_pc_plus4 = 32'h20;
    step();
    check_id("adv4", 32'h8C22_0004, 32'h20, 1'b1);
    check("sticky.timeout", 32'(stall_timeout), 32'h1);
`ifdef IF_ID_STALL_STATS_EN
    check("stats.stalls10", stall_cycles, 32'd10);
`endif

    // Asynchronous reset between edges while ID holds the lw.
    #3;
    rst = 1'b1;
    #1;
    check_id("async_rst", 32'h0, 32'h0, 1'b0);
    check("async_rst.timeout", 32'(stall_timeout), 32'h0);
    check_ctl("async_rst", 1'b0, 1'b0);
`ifdef IF_ID_STALL_STATS_EN
    check("stats.rst_stalls", stall_cycles, 32'd0);
    check("stats.rst_flush",  flush_count,  32'd0);
`endif
    #1;
    rst = 1'b0;

    // Fresh 8-cycle stall run.
    stall = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("wd7.timeout", 32'(stall_timeout), 32'h0);
    step();
    check("wd8.timeout", 32'(stall_timeout), 32'h1);
    check_id("wd_hold", 32'h0, 32'h0, 1'b0);
    stall = 1'b0; if_instruction = 32'h0043_2020; if_pc_plus4 = 32'h24;
    step();
    step();
    check("wd_sticky.timeout", 32'(stall_timeout), 32'h1);
    check_id("wd_adv", 32'h0043_2020, 32'h24, 1'b1);
`ifdef IF_ID_STALL_STATS_EN
    check("stats.wd_stalls", stall_cycles, 32'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_id_stall_register
